// File: rtl/tile_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tile_arbiter: round-robin arbiter giving three clients access to one tile-table port
// Rev 1.0
// ----------------------------------------------------------------------------
module tile_arbiter #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic        px_clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [17:0] req_x,
  input  logic [17:0] req_y,
  input  logic [23:0] req_data,
  output logic [2:0]  ack,
  output logic [2:0]  err,
  output logic [7:0]  rdata,
  output logic [5:0]  posx,
  output logic [5:0]  posy,
  output logic [7:0]  sprite,
  output logic        update,
  output logic        get,
  input  logic [7:0]  read_sprite,
  input  logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [6:0] COLS_W = 7'(COLS);
  localparam logic [6:0] ROWS_W = 7'(ROWS);

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  logic [2:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_q, gnt_d;
  logic       we_q, we_d;
  logic [5:0] x_q, x_d;
  logic [5:0] y_q, y_d;
  logic [7:0] data_q, data_d;
  logic [5:0] posx_q, posx_d;
  logic [5:0] posy_q, posy_d;
  logic [7:0] sprite_q, sprite_d;
  logic [7:0] rdata_q, rdata_d;
  logic       upd_q, upd_d;
  logic       get_q, get_d;

  logic [5:0] xs [3];
  logic [5:0] ys [3];
  logic [7:0] ds [3];

  for (genvar i = 0; i < 3; i++) begin : g_unpack
    assign xs[i] = req_x[6*i +: 6];
    assign ys[i] = req_y[6*i +: 6];
    assign ds[i] = req_data[8*i +: 8];
  end

  logic [1:0] idx0, idx1, idx2;
  logic [1:0] pick;
  logic       oob;
  logic [2:0] gnt_onehot;

  assign idx0 = ptr_q;
  assign idx1 = inc3(ptr_q);
  assign idx2 = inc3(idx1);

  // Later assignments win, so idx0 (the ptr slot) has top priority.
  always_comb begin
    pick = idx0;
    if (req[idx2]) pick = idx2;
    if (req[idx1]) pick = idx1;
    if (req[idx0]) pick = idx0;
  end

  assign oob        = ({1'b0, x_q} >= COLS_W) || ({1'b0, y_q} >= ROWS_W);
  assign gnt_onehot = 3'b001 << gnt_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    x_d      = x_q;
    y_d      = y_q;
    data_d   = data_q;
    posx_d   = posx_q;
    posy_d   = posy_q;
    sprite_d = sprite_q;
    rdata_d  = rdata_q;
    upd_d    = 1'b0;
    get_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          we_d    = we[pick];
          x_d     = xs[pick];
          y_d     = ys[pick];
          data_d  = ds[pick];
          state_d = S_CHECK;
        end
      end
      S_CHECK: state_d = oob ? S_IDLE : S_ISSUE;
      S_ISSUE: begin
        if (!busy) begin
          posx_d = x_q;
          posy_d = y_q;
          if (we_q) sprite_d = data_q;
          upd_d   = we_q;
          get_d   = !we_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!busy) begin
          if (!we_q) rdata_d = read_sprite;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = inc3(gnt_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 2'd0;
      gnt_q    <= 2'd0;
      we_q     <= 1'b0;
      x_q      <= 6'd0;
      y_q      <= 6'd0;
      data_q   <= 8'd0;
      posx_q   <= 6'd0;
      posy_q   <= 6'd0;
      sprite_q <= 8'd0;
      rdata_q  <= 8'd0;
      upd_q    <= 1'b0;
      get_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      x_q      <= x_d;
      y_q      <= y_d;
      data_q   <= data_d;
      posx_q   <= posx_d;
      posy_q   <= posy_d;
      sprite_q <= sprite_d;
      rdata_q  <= rdata_d;
      upd_q    <= upd_d;
      get_q    <= get_d;
    end
  end

  // Outputs are forced low combinationally so nothing leaks during the reset cycle itself.
  assign ack    = (state_q == S_DONE && !rst) ? gnt_onehot : 3'b000;
  assign err    = (state_q == S_CHECK && oob && !rst) ? gnt_onehot : 3'b000;
  assign update = upd_q & ~rst;
  assign get    = get_q & ~rst;
  assign rdata  = rst ? 8'd0 : rdata_q;
  assign posx   = rst ? 6'd0 : posx_q;
  assign posy   = rst ? 6'd0 : posy_q;
  assign sprite = rst ? 8'd0 : sprite_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tile_arbiter: directed and randomized checks of tile_arbiter against a transaction model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_tile_arbiter;

  localparam int COLS = 40;
  localparam int ROWS = 30;

  logic        px_clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [2:0]  we = 3'b000;
  logic [17:0] req_x = 18'd0;
  logic [17:0] req_y = 18'd0;
  logic [23:0] req_data = 24'd0;
  logic [7:0]  read_sprite = 8'd0;
  logic        busy = 1'b0;
  logic [2:0]  ack, err;
  logic [7:0]  rdata, sprite;
  logic [5:0]  posx, posy;
  logic        update, get;

  tile_arbiter #(.COLS(COLS), .ROWS(ROWS)) dut (
    .px_clk(px_clk), .rst(rst), .req(req), .we(we),
    .req_x(req_x), .req_y(req_y), .req_data(req_data),
    .ack(ack), .err(err), .rdata(rdata), .posx(posx), .posy(posy),
    .sprite(sprite), .update(update), .get(get),
    .read_sprite(read_sprite), .busy(busy)
  );

  always #5 px_clk = ~px_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model state
  int         mptr = 0;
  logic [5:0] m_px = 6'd0;
  logic [5:0] m_py = 6'd0;
  logic [7:0] m_sp = 8'd0;
  logic [7:0] m_rd = 8'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input int w, input int x, input int y, input int d);
    we[i]              = 1'(w);
    req_x[6*i +: 6]    = 6'(x);
    req_y[6*i +: 6]    = 6'(y);
    req_data[8*i +: 8] = 8'(d);
    req[i]             = 1'b1;
  endtask

  function automatic int rr_pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++)
      if (r[(p + k) % 3]) return (p + k) % 3;
    return 0;
  endfunction

  // Called in the IDLE cycle that will grant. bi/bw: busy cycles held in ISSUE/WAIT.
  // rst_at >= 0 pulses rst in that cycle and aborts; rs >= 0 fixes the read data.
  task automatic do_grant(input int bi, input int bw, input int rst_at, input bit zchk, input int rs);
    int         g;
    bit         e, w, seen;
    logic [5:0] x, y;
    logic [7:0] d, exp_rd;
    int         n_upd, n_get, t_strobe;
    g      = rr_pick(req, mptr);
    x      = req_x[6*g +: 6];
    y      = req_y[6*g +: 6];
    d      = req_data[8*g +: 8];
    w      = we[g];
    e      = (int'(x) >= COLS) || (int'(y) >= ROWS);
    seen   = 1'b0;
    n_upd  = 0;
    n_get  = 0;
    t_strobe = -1;
    exp_rd = m_rd;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (c >= 2 && c < 2 + bi)              busy = 1'b1;
      else if (c == 2 + bi)                  busy = 1'b0;
      else if (c > 2 + bi && c <= 2 + bi + bw) busy = 1'b1;
      else if (c == 3 + bi + bw)             busy = 1'b0;
      else                                   busy = 1'($urandom_range(0, 1));
      read_sprite = (rs >= 0 && c == 3 + bi + bw) ? 8'(rs) : 8'($urandom);
      if (c == 3 + bi + bw) exp_rd = read_sprite;
      if (c == rst_at) rst = 1'b1;
      @(negedge px_clk);
      if (c == rst_at) begin
        chk("rst_outputs_zero", {ack, err, update, get, rdata, posx, posy, sprite}, 64'd0);
        @(posedge px_clk); #1;
        rst  = 1'b0;
        mptr = 0;
        m_px = 6'd0; m_py = 6'd0; m_sp = 8'd0; m_rd = 8'd0;
        return;
      end
      if (zchk && c == 0)
        chk("post_rst_zero", {ack, err, update, get, rdata, posx, posy, sprite}, 64'd0);
      chk("upd_get_exclusive", update & get, 0);
      if (update | get) begin
        n_upd += int'(update);
        n_get += int'(get);
        t_strobe = c;
        chk("strobe_kind", {update, get}, w ? 2'b10 : 2'b01);
        chk("strobe_posxy", {posx, posy}, {x, y});
        chk("strobe_sprite", sprite, w ? d : m_sp);
      end
      if ((ack | err) != 3'b000) begin
        seen = 1'b1;
        chk("pulse_bits", {ack, err}, e ? {3'b000, 3'b001 << g} : {3'b001 << g, 3'b000});
        chk("pulse_latency", c, e ? 1 : 4 + bi + bw);
        chk("pos_hold", {posx, posy, sprite}, e ? {m_px, m_py, m_sp} : {x, y, (w ? d : m_sp)});
        if (!e && !w) chk("rdata", rdata, exp_rd);
      end
      @(posedge px_clk); #1;
    end
    chk("pulse_seen", seen, 1);
    chk("n_update", n_upd, (!e && w) ? 1 : 0);
    chk("n_get", n_get, (!e && !w) ? 1 : 0);
    if (!e) chk("strobe_cycle", t_strobe, 3 + bi);
    if (!e) begin
      mptr = (g + 1) % 3;
      m_px = x;
      m_py = y;
      if (w) m_sp = d;
      else   m_rd = exp_rd;
    end
    if (seen) req[g] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge px_clk);
    @(negedge px_clk);
    chk("reset_state", {ack, err, update, get, rdata, posx, posy, sprite}, 64'd0);
    @(posedge px_clk); #1;
    rst = 1'b0;

    // Write then read
    set_req(0, 1, 6, 6, 8'h07);
    do_grant(0, 0, -1, 0, -1);
    set_req(1, 0, 10, 3, 0);
    do_grant(0, 0, -1, 0, 8'h23);
    set_req(2, 1, 1, 2, 8'h55);
    do_grant(0, 0, -1, 0, -1);

    // Round robin with all three, then two re-raised
    for (int i = 0; i < 3; i++) set_req(i, $urandom_range(0, 1), $urandom_range(0, 39), $urandom_range(0, 29), $urandom_range(0, 255));
    repeat (3) do_grant(0, 0, -1, 0, -1);
    set_req(0, 1, 3, 4, 8'h9A);
    set_req(1, 0, 5, 6, 0);
    repeat (2) do_grant(0, 0, -1, 0, -1);

    // Range limits; ptr must not move after the error
    set_req(2, 1, 40, 0, 8'hAA);
    do_grant(0, 0, -1, 0, -1);
    set_req(0, 1, 1, 1, 8'h01);
    set_req(1, 0, 2, 2, 0);
    set_req(2, 1, 39, 29, 8'h3C);
    repeat (3) do_grant(0, 0, -1, 0, -1);
    set_req(0, 0, 0, 30, 0);
    do_grant(0, 0, -1, 0, -1);
    set_req(1, 1, 63, 63, 8'h44);
    do_grant(0, 0, -1, 0, -1);

    // Busy stretching in ISSUE, then in WAIT
    set_req(0, 1, 5, 5, 8'h11);
    do_grant(5, 0, -1, 0, -1);
    set_req(1, 0, 7, 8, 0);
    do_grant(0, 3, -1, 0, -1);

    // Reset while in WAIT, after ptr has moved off 0
    set_req(0, 1, 9, 9, 8'h66);
    do_grant(0, 0, -1, 0, -1);
    set_req(0, 1, 11, 12, 8'h77);
    set_req(1, 0, 13, 14, 0);
    do_grant(0, 6, 4, 0, -1);
    do_grant(0, 0, -1, 1, -1);
    do_grant(0, 0, -1, 0, -1);

    // Randomized traffic, including withdrawn requests
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1)
          set_req(i, $urandom_range(0, 1), $urandom_range(0, 44), $urandom_range(0, 33), $urandom_range(0, 255));
        else if (req[i] && $urandom_range(0, 7) == 0)
          req[i] = 1'b0;
      end
      if (req == 3'b000)
        set_req($urandom_range(0, 2), 0, $urandom_range(0, 39), $urandom_range(0, 29), 0);
      do_grant($urandom_range(0, 3), $urandom_range(0, 3), -1, 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
